// File: rtl/div_frac_seq_pkg.sv
// Shared Q-format constants, types and helpers for the fixed-point datapath.
// The divider below computes the inverse of fx_mul.
package div_frac_seq_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned FRAC_BITS  = 10;
    localparam int unsigned QUANT_VAL  = 1 << FRAC_BITS;

    // Quotient bits produced: the full |a| << FRAC_BITS dividend width.
    localparam int unsigned ITER  = DATA_WIDTH + FRAC_BITS + 1;
    localparam int unsigned MAG_W = DATA_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(ITER + 1);

    localparam logic [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef logic signed [DATA_WIDTH-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Q-format multiply: full-width product rescaled by the fraction bits.
    function automatic fixed_t fx_mul(fixed_t a, fixed_t b);
        logic signed [2*DATA_WIDTH-1:0] prod;
        prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        return fixed_t'(prod >>> FRAC_BITS);
    endfunction

    // Integer part of a Q-format value (floor).
    function automatic fixed_t fx_dequantize(fixed_t a);
        return a >>> FRAC_BITS;
    endfunction

endpackage

// File: rtl/div_frac_seq_if.sv
// Operand/result handshake bundle for the sequential fixed-point divider.
interface div_frac_seq_if;
    import div_frac_seq_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_div0;
    logic                  out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_q, out_div0, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_q, out_div0, out_ovf
    );

endinterface

// File: rtl/div_frac_seq.sv
// Multi-cycle signed Q-format divider: out = trunc((a << FRAC_BITS) / b).
// Restoring division on magnitudes, one quotient bit per clock, sign/saturation in a final cycle.
module div_frac_seq
    import div_frac_seq_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    div_frac_seq_if.slave bus
);

    localparam logic [ITER-1:0] MAG_NEG_LIM = ITER'(1) << (DATA_WIDTH - 1);
    localparam logic [ITER-1:0] MAG_POS_LIM = MAG_NEG_LIM - ITER'(1);

    div_state_t            state_q, state_d;
    logic [ITER-1:0]       dvd_q, dvd_d;
    logic [ITER-1:0]       quot_q, quot_d;
    logic [MAG_W-1:0]      bmag_q, bmag_d;
    logic [MAG_W-1:0]      rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  zero_q, zero_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  div0_q, div0_d;
    logic                  ovf_q, ovf_d;

    logic [MAG_W-1:0]      a_ext, b_ext, a_mag, b_mag;
    logic [MAG_W:0]        rem_shift;
    logic [MAG_W-1:0]      rem_sub;
    logic                  q_bit;

    // Next-state, datapath step and registered-output next values.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        quot_d      = quot_q;
        bmag_d      = bmag_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        res_d       = res_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;

        a_ext     = {bus.in_a[DATA_WIDTH-1], bus.in_a};
        b_ext     = {bus.in_b[DATA_WIDTH-1], bus.in_b};
        a_mag     = a_ext[MAG_W-1] ? (MAG_W'(0) - a_ext) : a_ext;
        b_mag     = b_ext[MAG_W-1] ? (MAG_W'(0) - b_ext) : b_ext;
        rem_shift = {rem_q, dvd_q[ITER-1]};
        q_bit     = (rem_shift >= {1'b0, bmag_q});
        // The true difference is below |b| whenever it is used, so modulo width is exact.
        rem_sub   = rem_shift[MAG_W-1:0] - bmag_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    dvd_d   = {a_mag, FRAC_BITS'(0)};
                    bmag_d  = b_mag;
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = '0;
                    // With b == 0 this reduces to sign(a), which picks the div0 rail.
                    neg_d   = bus.in_a[DATA_WIDTH-1] ^ bus.in_b[DATA_WIDTH-1];
                    zero_d  = (bus.in_b == '0);
                    state_d = (bus.in_b == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d  = q_bit ? rem_sub : rem_shift[MAG_W-1:0];
                quot_d = {quot_q[ITER-2:0], q_bit};
                dvd_d  = {dvd_q[ITER-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                div0_d = 1'b0;
                ovf_d  = 1'b0;
                if (zero_q) begin
                    res_d  = neg_q ? Q_MIN : Q_MAX;
                    div0_d = 1'b1;
                end else if (!neg_q) begin
                    if (quot_q > MAG_POS_LIM) begin
                        res_d = Q_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        res_d = quot_q[DATA_WIDTH-1:0];
                    end
                end else begin
                    if (quot_q > MAG_NEG_LIM) begin
                        res_d = Q_MIN;
                        ovf_d = 1'b1;
                    end else begin
                        res_d = DATA_WIDTH'(0) - quot_q[DATA_WIDTH-1:0];
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            quot_q      <= '0;
            bmag_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            quot_q      <= quot_d;
            bmag_q      <= bmag_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_q     = res_q;
    assign bus.out_div0  = div0_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_div_frac_seq.sv
// Self-checking bench for div_frac_seq: directed corner cases, backpressure,
// mid-operation reset and random operands against a 64-bit arithmetic reference.
module tb_div_frac_seq;

    localparam int LAT_NORM = 32 + 10 + 1 + 2;
    localparam int LAT_DIV0 = 2;
    localparam int BOUND    = 200;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    div_frac_seq_if bus_if ();

    div_frac_seq dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors: a, b, expected quotient, div0, ovf.
    logic [31:0] d_a  [9] = '{32'h00000C00, 32'hFFFFFC00, 32'h00000400, 32'hFFFFFC00,
                              32'h40000000, 32'h80000000, 32'h80000000, 32'h00000000,
                              32'hFFFFFFFF};
    logic [31:0] d_b  [9] = '{32'h00000800, 32'h00000C00, 32'h00000000, 32'h00000000,
                              32'h00000001, 32'h00000400, 32'hFFFFFC00, 32'h00000123,
                              32'h7FFFFFFF};
    logic [31:0] d_q  [9] = '{32'h00000600, 32'hFFFFFEAB, 32'h7FFFFFFF, 32'h80000000,
                              32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000,
                              32'h00000000};
    logic        d_d0 [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        d_ov [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer division of a*2^10 by b, then clamp to 32 bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic d0, output logic ov);
        longint num;
        longint quo;
        d0 = 1'b0;
        ov = 1'b0;
        if (b == 32'h0) begin
            d0 = 1'b1;
            q  = ($signed(a) < 0) ? 32'h80000000 : 32'h7FFFFFFF;
        end else begin
            num = longint'($signed(a)) * 1024;
            quo = num / longint'($signed(b));
            if (quo > 64'sd2147483647) begin
                q  = 32'h7FFFFFFF;
                ov = 1'b1;
            end else if (quo < -64'sd2147483648) begin
                q  = 32'h80000000;
                ov = 1'b1;
            end else begin
                q = quo[31:0];
            end
        end
    endfunction

    // Present operands and return #1 after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        bus_if.in_valid = 1'b1;
        while (bus_if.in_ready !== 1'b1 && guard < BOUND) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("accept_timeout", 64'(guard < BOUND), 64'd1);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge (inclusive) until out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus_if.out_valid !== 1'b1 && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string tag, input logic [31:0] eq, input logic ed,
                             input logic eo, input int elat);
        int lat;
        wait_valid(lat);
        chk({tag, "_lat"},  64'(lat), 64'(elat));
        chk({tag, "_q"},    64'(bus_if.out_q), 64'(eq));
        chk({tag, "_div0"}, 64'(bus_if.out_div0), 64'(ed));
        chk({tag, "_ovf"},  64'(bus_if.out_ovf), 64'(eo));
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        chk({tag, "_vld_drop"}, 64'(bus_if.out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(bus_if.in_ready), 64'd1);
        chk({tag, "_q_hold"},   64'(bus_if.out_q), 64'(eq));
    endtask

    initial begin
        logic [31:0] ra, rb, eq;
        logic        ed, eo;
        int          sel, lat;

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus_if.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_out_q",     64'(bus_if.out_q), 64'd0);
        chk("rst_div0",      64'(bus_if.out_div0), 64'd0);
        chk("rst_ovf",       64'(bus_if.out_ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases.
        for (int i = 0; i < 9; i++) begin
            start_op(d_a[i], d_b[i]);
            finish_op($sformatf("dir%0d", i), d_q[i], d_d0[i], d_ov[i],
                      (d_b[i] == 32'h0) ? LAT_DIV0 : LAT_NORM);
        end

        // Backpressure: result held, second operand waits for the out handshake.
        start_op(32'h00001400, 32'h00000400);
        wait_valid(lat);
        chk("bp_lat", 64'(lat), 64'(LAT_NORM));
        chk("bp_q",   64'(bus_if.out_q), 64'h1400);
        bus_if.in_a     = 32'hFFFFF800;
        bus_if.in_b     = 32'h00000800;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_vld", 64'(bus_if.out_valid), 64'd1);
            chk("bp_hold_rdy", 64'(bus_if.in_ready), 64'd0);
            chk("bp_hold_q",   64'(bus_if.out_q), 64'h1400);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        chk("bp_hs_vld", 64'(bus_if.out_valid), 64'd0);
        chk("bp_hs_rdy", 64'(bus_if.in_ready), 64'd1);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        chk("bp_accept", 64'(bus_if.in_ready), 64'd0);
        finish_op("bp2", 32'hFFFFFC00, 1'b0, 1'b0, LAT_NORM);

        // Reset in the middle of an iteration run.
        start_op(32'h12345678, 32'h00000003);
        repeat (19) @(posedge clk);
        #1;
        chk("mid_busy", 64'(bus_if.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(bus_if.out_valid), 64'd0);
        chk("mid_rst_rdy", 64'(bus_if.in_ready), 64'd1);
        chk("mid_rst_q",   64'(bus_if.out_q), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_vld", 64'(bus_if.out_valid), 64'd0);
        start_op(32'h00000800, 32'h00000400);
        finish_op("post_rst", 32'h00000800, 1'b0, 1'b0, LAT_NORM);

        // Random operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 4);
            case (sel)
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 4096));
                2:       rb = 32'h0 - 32'($urandom_range(1, 4096));
                default: rb = $urandom;
            endcase
            if (sel == 4) ra = 32'($signed(ra) >>> $urandom_range(0, 30));
            model(ra, rb, eq, ed, eo);
            start_op(ra, rb);
            finish_op($sformatf("rnd%0d", i), eq, ed, eo,
                      (rb == 32'h0) ? LAT_DIV0 : LAT_NORM);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
